// File: rtl/bcd_timer_pkg.sv
// bcd_timer_pkg: shared types and constants for the cascaded BCD timer.
//   state_e  - controller FSM states (IDLE, RUN, PAUSE, DONE)
//   DIGIT_W  - bits per BCD digit
//   BCD_MAX  - largest legal digit value
//   bcd_sat  - clamps a nibble into the legal BCD range
package bcd_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int                  DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0]  BCD_MAX = 4'd9;

  // Any nibble above 9 is treated as 9 so a digit can never hold a non-BCD code.
  function automatic logic [DIGIT_W-1:0] bcd_sat(input logic [DIGIT_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_timer_if.sv
// bcd_timer_if: command/status bundle of the BCD timer.
//   clear, load, preset, start, stop, dir : commands towards the timer
//   q, running, done, tc                  : status from the timer
// master = command source (e.g. a testbench or host), slave = the timer.
interface bcd_timer_if #(
  parameter int DIGITS = 4
);

  logic                  clear;
  logic                  load;
  logic [4*DIGITS-1:0]   preset;
  logic                  start;
  logic                  stop;
  logic                  dir;
  logic [4*DIGITS-1:0]   q;
  logic                  running;
  logic                  done;
  logic                  tc;

  modport master (
    output clear, load, preset, start, stop, dir,
    input  q, running, done, tc
  );

  modport slave (
    input  clear, load, preset, start, stop, dir,
    output q, running, done, tc
  );

endinterface

// File: rtl/bcd_digit_cell.sv
// bcd_digit_cell: one decimal digit of the counter chain.
//   clk, rst    : clock, synchronous active-high reset
//   clr_i       : zero the digit
//   load_i      : load load_val_i (clamped to 9)
//   load_val_i  : preset nibble
//   en_i        : step enable (tick for digit 0, tied high above)
//   dir_i       : 0 = up, 1 = down
//   cin_i       : carry/borrow from the lower digit
//   cout_o      : carry/borrow into the next digit
//   q_o         : registered digit value
module bcd_digit_cell
  import bcd_timer_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr_i,
  input  logic               load_i,
  input  logic [DIGIT_W-1:0] load_val_i,
  input  logic               en_i,
  input  logic               dir_i,
  input  logic               cin_i,
  output logic               cout_o,
  output logic [DIGIT_W-1:0] q_o
);

  logic [DIGIT_W-1:0] q_q;
  logic [DIGIT_W-1:0] q_d;
  logic               step_s;
  logic               at_lim_s;

  // Next digit value: clear > load > step; wraps 9->0 up and 0->9 down.
  always_comb begin
    step_s   = en_i & cin_i;
    at_lim_s = dir_i ? (q_q == 4'd0) : (q_q == BCD_MAX);
    q_d      = q_q;
    if (clr_i) begin
      q_d = 4'd0;
    end else if (load_i) begin
      q_d = bcd_sat(load_val_i);
    end else if (step_s) begin
      if (dir_i) begin
        q_d = at_lim_s ? BCD_MAX : (q_q - 4'd1);
      end else begin
        q_d = at_lim_s ? 4'd0 : (q_q + 4'd1);
      end
    end else begin
      q_d = q_q;
    end
  end

  // Ripple carry/borrow: only when this digit actually steps across its limit.
  assign cout_o = step_s & at_lim_s;
  assign q_o    = q_q;

  // Digit register.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

endmodule

// File: rtl/bcd_timer_ctrl.sv
// bcd_timer_ctrl: prescaled up/down BCD timer with IDLE/RUN/PAUSE/DONE control.
//   DIGITS   : number of cascaded BCD digits
//   PRESCALE : clk cycles per count tick while running (1..65535)
//   clk, rst : clock, synchronous active-high reset
//   bus      : bcd_timer_if.slave (commands in, q/running/done/tc out)
// Build option: define BCD_TIMER_WRAP_EN to keep running through the terminal
// value (q wraps, tc still pulses, DONE is never entered).
module bcd_timer_ctrl
  import bcd_timer_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int PRESCALE = 10
) (
  input  logic        clk,
  input  logic        rst,
  bcd_timer_if.slave  bus
);

  localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

  state_e              state_q, state_d;
  logic [15:0]         presc_q, presc_d;
  logic                dir_q, dir_d;
  logic                tc_q, tc_d;
  logic                running_q;
  logic                done_q;

  logic [4*DIGITS-1:0] q_s;
  logic [DIGITS:0]     carry_s;
  logic                clr_s, load_s, start_s, tick_s;
  logic                all9_s, all0_s, up_hit_s, dn_hit_s, hit_s, start_term_s;

  // ---------------- digit chain ----------------
  assign carry_s[0] = 1'b1;

  genvar g;
  generate
    for (g = 0; g < DIGITS; g++) begin : g_digit
      bcd_digit_cell u_cell (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (clr_s),
        .load_i     (load_s),
        .load_val_i (bus.preset[g*DIGIT_W +: DIGIT_W]),
        .en_i       ((g == 0) ? tick_s : 1'b1),
        .dir_i      (dir_q),
        .cin_i      (carry_s[g]),
        .cout_o     (carry_s[g+1]),
        .q_o        (q_s[g*DIGIT_W +: DIGIT_W])
      );
    end
  endgenerate

  // Terminal detection: already at all-9/all-0, or one tick away from it.
  always_comb begin
    all9_s   = 1'b1;
    all0_s   = 1'b1;
    up_hit_s = (q_s[DIGIT_W-1:0] == 4'd8);
    dn_hit_s = (q_s[DIGIT_W-1:0] == 4'd1);
    for (int i = 0; i < DIGITS; i++) begin
      all9_s = all9_s & (q_s[i*DIGIT_W +: DIGIT_W] == BCD_MAX);
      all0_s = all0_s & (q_s[i*DIGIT_W +: DIGIT_W] == 4'd0);
    end
    for (int i = 1; i < DIGITS; i++) begin
      up_hit_s = up_hit_s & (q_s[i*DIGIT_W +: DIGIT_W] == BCD_MAX);
      dn_hit_s = dn_hit_s & (q_s[i*DIGIT_W +: DIGIT_W] == 4'd0);
    end
    hit_s        = dir_q   ? dn_hit_s : up_hit_s;
    start_term_s = bus.dir ? all0_s   : all9_s;
  end

  // Command decode with priority clear > stop > load > start; stop only matters in RUN.
  always_comb begin
    clr_s   = bus.clear;
    load_s  = bus.load  & ~bus.clear & (state_q != ST_RUN);
    start_s = bus.start & ~bus.clear & ~bus.load & (state_q != ST_RUN);
    tick_s  = (state_q == ST_RUN) & ~bus.clear & ~bus.stop & (presc_q == PRESC_LAST);
  end

  // Controller next state, prescaler, latched direction and tc.
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    dir_d   = dir_q;
    tc_d    = 1'b0;
    if (clr_s) begin
      state_d = ST_IDLE;
      presc_d = 16'd0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (bus.stop) begin
            state_d = ST_PAUSE;
          end else if (tick_s) begin
            presc_d = 16'd0;
            tc_d    = hit_s;
`ifdef BCD_TIMER_WRAP_EN
            state_d = ST_RUN;
`else
            // A carry out of the top digit can only follow a missed terminal;
            // parking in DONE keeps q from wrapping in the non-wrap build.
            state_d = (hit_s | carry_s[DIGITS]) ? ST_DONE : ST_RUN;
`endif
          end else begin
            presc_d = presc_q + 16'd1;
          end
        end
        ST_IDLE, ST_PAUSE, ST_DONE: begin
          if (load_s) begin
            state_d = ST_IDLE;
          end else if (start_s) begin
            dir_d   = bus.dir;
            presc_d = 16'd0;
`ifdef BCD_TIMER_WRAP_EN
            state_d = ST_RUN;
`else
            // Starting at the terminal value finishes immediately, no tick.
            state_d = start_term_s ? ST_DONE : ST_RUN;
`endif
          end else begin
            state_d = state_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM registers and registered status flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      presc_q   <= 16'd0;
      dir_q     <= 1'b0;
      tc_q      <= 1'b0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      dir_q     <= dir_d;
      tc_q      <= tc_d;
      running_q <= (state_d == ST_RUN);
      done_q    <= (state_d == ST_DONE);
    end
  end

  assign bus.q       = q_s;
  assign bus.running = running_q;
  assign bus.done    = done_q;
  assign bus.tc      = tc_q;

endmodule

// File: doc/bcd_timer_ctrl.md
BCD_TIMER_CTRL -- requirements
Module: bcd_timer_ctrl

Interface
REQ-001 Parameter DIGITS, default 4: number of cascaded BCD digits in the chain.
REQ-002 Parameter PRESCALE, default 10: clk cycles per count tick while running; legal range 1 to 65535.
REQ-003 clk  in  1  sole clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 clear  in  1  return to IDLE with count zeroed.
REQ-006 load  in  1  copy preset into count.
REQ-007 preset  in  4*DIGITS  BCD load value, digit 0 in the least significant nibble.
REQ-008 start  in  1  begin or resume counting.
REQ-009 stop  in  1  pause counting.
REQ-010 dir  in  1  count direction, 0 = up, 1 = down; sampled only when start is accepted.
REQ-011 q  out  4*DIGITS  current BCD count.
REQ-012 running  out  1  high while in RUN.
REQ-013 done  out  1  high while in DONE.
REQ-014 tc  out  1  one-cycle pulse on the tick that makes q reach the terminal value.

Function
REQ-015 The FSM SHALL have four states: IDLE, RUN, PAUSE, DONE.
REQ-016 Command priority SHALL be rst > clear > stop > load > start.
REQ-017 clear SHALL act from any state: next cycle state = IDLE, q = 0, prescaler = 0.
REQ-018 load SHALL act in IDLE, PAUSE and DONE: next cycle q = preset, state = IDLE; any preset digit above 9 loads as 9.
REQ-019 load SHALL be ignored in RUN.
REQ-020 start SHALL be accepted in IDLE, PAUSE and DONE: it latches dir, enters RUN and clears the prescaler.
REQ-021 If start is accepted while q already equals the terminal value for the latched dir, the block SHALL enter DONE next cycle; no tick and no tc occur.
REQ-022 stop in RUN SHALL enter PAUSE next cycle, freezing q and the prescaler.
REQ-023 stop outside RUN SHALL be ignored.
REQ-024 start and stop together in RUN SHALL resolve as stop.
REQ-025 In RUN, the prescaler SHALL count 0 to PRESCALE-1; a tick occurs on the cycle it equals PRESCALE-1, and it then wraps to 0.
REQ-026 The first tick SHALL occur PRESCALE cycles after RUN is entered.
REQ-027 On a tick, q SHALL update at that same clock edge: +1 with decimal carry for up (0009 -> 0010), -1 with decimal borrow for down (0010 -> 0009).
REQ-028 A digit SHALL never leave the range 0 to 9.
REQ-029 The terminal value SHALL be all 9s for up and all 0s for down.
REQ-030 On the tick that makes q reach the terminal value, tc SHALL pulse high and the state SHALL become DONE (see REQ-036).
REQ-031 In DONE, q SHALL hold until clear, load or start.
REQ-032 running SHALL equal (state == RUN) and done SHALL equal (state == DONE), both registered.

Reset
REQ-033 While rst is sampled high: state = IDLE, q = 0, prescaler = 0, latched dir = 0, running = 0, done = 0, tc = 0.
REQ-034 rst SHALL override every other input, including mid-count in RUN.

Configuration
REQ-035 Macro BCD_TIMER_WRAP_EN undefined: terminal behaviour is as in REQ-030.
REQ-036 BCD_TIMER_WRAP_EN defined: the terminal tick still pulses tc, but the state stays RUN and the next tick wraps q (9999 -> 0000 up, 0000 -> 9999 down); REQ-021 does not apply and DONE is unreachable.

Structure
REQ-037 Package bcd_timer_pkg SHALL hold the FSM state enum, DIGIT_W = 4 and BCD_MAX = 9.
REQ-038 The datapath SHALL be DIGITS instances of sub-module bcd_digit_cell, each with enable, dir, load value, carry/borrow in and out, and 4-bit q.
REQ-039 The digits SHALL be chained by carry/borrow; the controller drives only digit 0's enable with the tick.

Verification (DIGITS = 4, PRESCALE = 2)
REQ-040 rst for 1 cycle, then start with dir = 0 -> q = 0001 after 2 cycles and 0002 after 4; running = 1.
REQ-041 load preset 0099, start with dir = 0, run 2 ticks -> q goes 0100 then 0101.
REQ-042 load preset 0001, start with dir = 1 -> after 2 cycles q = 0000, tc pulses for 1 cycle, done = 1; unchanged 10 cycles later.
REQ-043 Assert stop and start together mid-RUN -> PAUSE, q frozen; start alone -> the next tick occurs 2 cycles later.
REQ-044 load in RUN -> ignored; load preset A9F3 in IDLE -> q = 9993.
REQ-045 With BCD_TIMER_WRAP_EN defined: preset 9998, start with dir = 0 -> 9999 with tc pulse, then 0000; running stays 1.
